// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment scan controller: active-low segment
// codes ({g,f,e,d,c,b,a}), slot-phase enum and scan timing helper.
package display_pkg;

  // All segments off (common-anode, active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex digit glyphs, active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Phase within one digit slot
  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_t;

  // Clock cycles per digit slot
  function automatic int calc_tick_max(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup for the current nibble
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Each digit slot opens with an all-dark interval to suppress ghosting;
// host updates are double-buffered and only take effect at a frame wrap.
module seven_seg_scan_ctrl
  import display_pkg::*;
#(
  parameter int CLK_HZ       = 100000000,
  parameter int SCAN_HZ      = 1000,
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    frame_done
);

  localparam int TICK_MAX = calc_tick_max(CLK_HZ, SCAN_HZ);
  localparam int CNT_W    = $clog2(TICK_MAX);
  localparam int IDX_W    = $clog2(NUM_DIGITS);
  localparam int BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Reject parameter sets that cannot produce a visible slot
  generate
    if (TICK_MAX < 2) begin : g_bad_tick
      $error("TICK_MAX must be at least 2");
    end
    if (BLANK_CYCLES >= TICK_MAX) begin : g_bad_blank
      $error("BLANK_CYCLES must be smaller than TICK_MAX");
    end
    if (NUM_DIGITS < 2) begin : g_bad_digits
      $error("NUM_DIGITS must be at least 2");
    end
  endgenerate

  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [4*NUM_DIGITS-1:0] act_digits_reg, pend_digits_reg;
  logic [NUM_DIGITS-1:0]   act_blank_reg, pend_blank_reg;
  logic [NUM_DIGITS-1:0]   act_blink_reg, pend_blink_reg;
  logic                    pend_flag_reg;
  logic [BLK_W-1:0]        blink_cnt_reg;
  logic                    blink_phase_reg;
  logic [NUM_DIGITS-1:0]   anode_reg, anode_next;
  logic [6:0]              seg_reg, seg_next;
  logic                    load_ack_reg, frame_done_reg;

  slot_state_t slot_state;
  logic        cnt_wrap, frame_end, digit_dark;
  logic [3:0]  nibble_arr [NUM_DIGITS];
  logic [3:0]  cur_nibble;
  logic [6:0]  dec_seg;

  // Split the active digit vector into per-digit nibbles for the index mux
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
      assign nibble_arr[gi] = act_digits_reg[4*gi +: 4];
    end
  endgenerate

  assign slot_state = (cnt_reg < CNT_W'(BLANK_CYCLES)) ? SLOT_BLANK : SLOT_DRIVE;
  assign cnt_wrap   = (cnt_reg == CNT_W'(TICK_MAX - 1));
  assign frame_end  = cnt_wrap && (idx_reg == IDX_W'(NUM_DIGITS - 1));
  assign cur_nibble = nibble_arr[idx_reg];
  assign digit_dark = act_blank_reg[idx_reg] | (act_blink_reg[idx_reg] & blink_phase_reg);

  hex_to_7seg u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // Next anode/segment pattern from the current slot phase and digit
  always_comb begin
    anode_next = '1;
    seg_next   = SEG_BLANK;
    if (slot_state == SLOT_DRIVE) begin
      anode_next[idx_reg] = 1'b0;
      seg_next            = digit_dark ? SEG_BLANK : dec_seg;
    end
  end

  // Slot counter and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (cnt_wrap) begin
      cnt_reg <= '0;
      idx_reg <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Registered display outputs and frame pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_reg      <= '1;
      seg_reg        <= SEG_BLANK;
      frame_done_reg <= 1'b0;
    end else begin
      anode_reg      <= anode_next;
      seg_reg        <= seg_next;
      frame_done_reg <= frame_end;
    end
  end

  // Double buffer: pending data promotes to active only at a frame wrap;
  // a load on the wrap cycle itself waits for the following wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_digits_reg  <= '0;
      act_blank_reg   <= '0;
      act_blink_reg   <= '0;
      pend_digits_reg <= '0;
      pend_blank_reg  <= '0;
      pend_blink_reg  <= '0;
      pend_flag_reg   <= 1'b0;
      load_ack_reg    <= 1'b0;
    end else begin
      load_ack_reg <= frame_end & pend_flag_reg;
      if (frame_end && pend_flag_reg) begin
        act_digits_reg <= pend_digits_reg;
        act_blank_reg  <= pend_blank_reg;
        act_blink_reg  <= pend_blink_reg;
      end
      if (load) begin
        pend_digits_reg <= digits_in;
        pend_blank_reg  <= blank_mask;
        pend_blink_reg  <= blink_mask;
        pend_flag_reg   <= 1'b1;
      end else if (frame_end) begin
        pend_flag_reg <= 1'b0;
      end
    end
  end

  // Blink phase toggles every BLINK_FRAMES complete frames
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt_reg == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign anode      = anode_reg;
  assign seg        = seg_reg;
  assign load_ack   = load_ack_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl with a small timing configuration
// (10 cycles per slot, 2 blank cycles, 4 digits, blink every 2 frames).
module tb_seven_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int TM = 10;
  localparam int BC = 2;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask, blink_mask;
  logic        load;
  logic        load_ack, frame_done;
  logic [3:0]  anode;
  logic [6:0]  seg;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .CLK_HZ       (100),
    .SCAN_HZ      (10),
    .NUM_DIGITS   (N),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .load       (load),
    .load_ack   (load_ack),
    .anode      (anode),
    .seg        (seg),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       ack;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model state; m_t counts clock edges since reset release
  int          m_t;
  logic [15:0] m_act_d, m_pend_d;
  logic [3:0]  m_act_bl, m_pend_bl, m_act_bk, m_pend_bk;
  bit          m_pend;
  int          m_bcnt;
  bit          m_phase;

  int         n_cmp = 0;
  int         n_err = 0;
  int         ack_seen, fd_seen, a0;
  logic [6:0] obs_seg [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    m_act_d = '0; m_pend_d = '0;
    m_act_bl = '0; m_pend_bl = '0;
    m_act_bk = '0; m_pend_bk = '0;
    m_pend = 1'b0; m_bcnt = 0; m_phase = 1'b0;
    ack_seen = 0; fd_seen = 0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, predict the post-edge outputs, then compare
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk);
    int   cnt, idx;
    exp_t e, got;
    cnt = m_t % TM;
    idx = (m_t / TM) % N;
    load = ld; digits_in = d; blank_mask = bl; blink_mask = bk;
    if (ld) $display("load t=%0d digits=%h blank=%b blink=%b", m_t, d, bl, bk);
    e.anode = 4'hF; e.seg = 7'h7F; e.ack = 1'b0; e.fd = 1'b0;
    if (cnt >= BC) begin
      e.anode[idx] = 1'b0;
      if (!(m_act_bl[idx] || (m_act_bk[idx] && m_phase)))
        e.seg = seg_tab[m_act_d[4*idx +: 4]];
    end
    if (cnt == TM - 1 && idx == N - 1) begin
      e.fd  = 1'b1;
      e.ack = m_pend;
      if (m_bcnt + 1 == BF) begin
        m_bcnt  = 0;
        m_phase = !m_phase;
      end else begin
        m_bcnt++;
      end
      if (m_pend) begin
        m_act_d = m_pend_d; m_act_bl = m_pend_bl; m_act_bk = m_pend_bk;
        m_pend  = 1'b0;
      end
    end
    if (ld) begin
      m_pend_d = d; m_pend_bl = bl; m_pend_bk = bk;
      m_pend = 1'b1;
    end
    exp_q.push_back(e);
    @(negedge clk);
    load = 1'b0;
    got = exp_q.pop_front();
    chk("anode", anode, got.anode);
    chk("seg", seg, got.seg);
    chk("load_ack", load_ack, got.ack);
    chk("frame_done", frame_done, got.fd);
    chk("one_anode_low", ($countones(~anode) <= 1), 1);
    if (load_ack) begin
      ack_seen++;
      $display("load_ack t=%0d", m_t);
    end
    if (frame_done) fd_seen++;
    if (cnt == 5) obs_seg[idx] = seg;
    m_t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  // Advance until the scan position (counter, index) is reached
  task automatic run_to(input int c, input int ix);
    for (int g = 0; g <= 200; g++) begin
      if ((m_t % TM) == c && ((m_t / TM) % N) == ix) return;
      if (g == 200) begin
        chk("run_to_timeout", 1, 0);
        return;
      end
      step(1'b0, 16'h0, 4'h0, 4'h0);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; digits_in = '0; blank_mask = '0; blink_mask = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_anode", anode, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_ack", load_ack, 0);
    chk("rst_fd", frame_done, 0);
    reset = 1'b0;

    // 1: free-running scan with default (all zero) data
    idle(80);
    chk("t1_frames", fd_seen, 2);
    chk("t1_acks", ack_seen, 0);
    chk("t1_dig0", obs_seg[0], 7'b1000000);

    // 2: mid-frame load applied at the next frame boundary
    run_to(5, 1);
    step(1'b1, 16'hF810, 4'h0, 4'h0);
    run_to(9, 3);
    chk("t2_no_early_ack", ack_seen, 0);
    step(1'b0, 16'h0, 4'h0, 4'h0);
    chk("t2_ack", ack_seen, 1);
    idle(40);
    chk("t2_dig0", obs_seg[0], 7'b1000000);
    chk("t2_dig1", obs_seg[1], 7'b1111001);
    chk("t2_dig2", obs_seg[2], 7'b0000000);
    chk("t2_dig3", obs_seg[3], 7'b0001110);
    chk("t2_ack_total", ack_seen, 1);

    // 3: two loads in one frame, last wins, single ack
    a0 = ack_seen;
    run_to(3, 0);
    step(1'b1, 16'h1111, 4'h0, 4'h0);
    run_to(3, 2);
    step(1'b1, 16'h2222, 4'h0, 4'h0);
    run_to(9, 3);
    step(1'b0, 16'h0, 4'h0, 4'h0);
    idle(40);
    chk("t3_single_ack", ack_seen - a0, 1);
    for (int i = 0; i < N; i++) chk("t3_dig", obs_seg[i], 7'b0100100);

    // 4: load on the boundary cycle is deferred one frame
    run_to(9, 3);
    a0 = ack_seen;
    step(1'b1, 16'h3333, 4'h0, 4'h0);
    chk("t4_no_ack_now", ack_seen - a0, 0);
    idle(39);
    chk("t4_no_ack_yet", ack_seen - a0, 0);
    step(1'b0, 16'h0, 4'h0, 4'h0);
    chk("t4_ack_next", ack_seen - a0, 1);
    idle(40);
    chk("t4_dig0", obs_seg[0], 7'b0110000);

    // 5: blink and blank masks from a fresh reset
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1'b1, 16'h1234, 4'b1000, 4'b0001);
    idle(39);
    chk("t5_f0_dig0", obs_seg[0], 7'b1000000);
    for (int f = 1; f <= 4; f++) begin
      idle(40);
      chk("t5_dig0", obs_seg[0], (f == 2 || f == 3) ? 7'h7F : 7'b0011001);
      chk("t5_dig3", obs_seg[3], 7'h7F);
    end

    // 6: asynchronous reset during DRIVE of digit 2
    run_to(6, 2);
    chk("t6_pre_anode", anode, 4'b1011);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_anode", anode, 4'hF);
    chk("t6_async_seg", seg, 7'h7F);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(2);
    chk("t6_blank_anode", anode, 4'hF);
    idle(1);
    chk("t6_first_anode", anode, 4'b1110);
    chk("t6_first_seg", seg, 7'b1000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
